// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - countdown timer control FSM: key handling, BCD preset editing, count enable, preset load; optional COUNTDOWN_ALARM_TIMEOUT_EN alarm auto-clear
// Ports: CP clock, CR sync active-low reset, TICK 1 Hz strobe, K_START/K_SET/K_SEL/K_INC key pulses,
//        TC counter-at-zero flag; CE count enable, PE preset load, D_H/D_M/D_S BCD presets,
//        SEL edited field, ALARM alarm flag, STATE state encoding.
module countdown_ctrl #(
    parameter logic [7:0] ALARM_SEC = 8'd30
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       TICK,
    input  logic       K_START,
    input  logic       K_SET,
    input  logic       K_SEL,
    input  logic       K_INC,
    input  logic       TC,
    output logic       CE,
    output logic       PE,
    output logic [7:0] D_H,
    output logic [7:0] D_M,
    output logic [7:0] D_S,
    output logic [1:0] SEL,
    output logic       ALARM,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    state_t     state, state_next;
    logic       ce_next, pe_next;
    logic [1:0] sel_next;
    logic [7:0] d_h_next, d_m_next, d_s_next;
    logic       preset_nonzero;

    // Two-digit BCD increment that wraps to 00 after max (no carry out).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign preset_nonzero = |{D_H, D_M, D_S};

`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
    logic [7:0] alarm_cnt, alarm_cnt_next;
    logic       alarm_timeout;

    // Timeout fires on the ALARM_SEC-th tick seen while in ALARM.
    assign alarm_timeout = TICK && (alarm_cnt == ALARM_SEC - 8'd1);

    always_comb begin
        alarm_cnt_next = 8'd0;
        if (state == ST_ALARM && state_next == ST_ALARM)
            alarm_cnt_next = TICK ? alarm_cnt + 8'd1 : alarm_cnt;
    end

    always_ff @(posedge CP) begin
        if (!CR)
            alarm_cnt <= 8'd0;
        else
            alarm_cnt <= alarm_cnt_next;
    end
`else
    logic unused_alarm_sec;
    assign unused_alarm_sec = ^ALARM_SEC;
`endif

    always_comb begin
        state_next = state;
        ce_next    = 1'b0;
        pe_next    = 1'b0;
        sel_next   = SEL;
        d_h_next   = D_H;
        d_m_next   = D_M;
        d_s_next   = D_S;
        case (state)
            ST_IDLE: begin
                if (K_SET) begin
                    state_next = ST_SET;
                    sel_next   = 2'd0;
                end else if (K_START && preset_nonzero) begin
                    state_next = ST_RUN;
                end
            end
            ST_SET: begin
                // Keys are resolved strictly by priority; K_START has no
                // action here but still masks the lower-priority keys.
                if (K_SET) begin
                    state_next = ST_IDLE;
                    pe_next    = 1'b1;
                end else if (K_START) begin
                    state_next = ST_SET;
                end else if (K_SEL) begin
                    sel_next = (SEL == 2'd2) ? 2'd0 : SEL + 2'd1;
                end else if (K_INC) begin
                    case (SEL)
                        2'd0:    d_s_next = bcd_inc(D_S, 8'h59);
                        2'd1:    d_m_next = bcd_inc(D_M, 8'h59);
                        default: d_h_next = bcd_inc(D_H, 8'h23);
                    endcase
                end
            end
            ST_RUN: begin
                // TC beats K_START; CE only follows a tick while staying in RUN.
                if (TC)
                    state_next = ST_ALARM;
                else if (K_START)
                    state_next = ST_PAUSE;
                else
                    ce_next = TICK;
            end
            ST_PAUSE: begin
                if (K_SET) begin
                    state_next = ST_SET;
                    sel_next   = 2'd0;
                end else if (K_START) begin
                    state_next = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (K_SET || K_START) begin
                    state_next = ST_IDLE;
                    pe_next    = 1'b1;
                end
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
                else if (alarm_timeout) begin
                    state_next = ST_IDLE;
                    pe_next    = 1'b1;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CP) begin
        if (!CR) begin
            state <= ST_IDLE;
            CE    <= 1'b0;
            PE    <= 1'b0;
            SEL   <= 2'd0;
            D_H   <= 8'h00;
            D_M   <= 8'h00;
            D_S   <= 8'h00;
        end else begin
            state <= state_next;
            CE    <= ce_next;
            PE    <= pe_next;
            SEL   <= sel_next;
            D_H   <= d_h_next;
            D_M   <= d_m_next;
            D_S   <= d_s_next;
        end
    end

    assign ALARM = (state == ST_ALARM);
    assign STATE = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl
module tb_countdown_ctrl;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       TICK = 1'b0;
    logic       K_START = 1'b0;
    logic       K_SET = 1'b0;
    logic       K_SEL = 1'b0;
    logic       K_INC = 1'b0;
    logic       TC = 1'b0;
    logic       CE, PE, ALARM;
    logic [7:0] D_H, D_M, D_S;
    logic [1:0] SEL;
    logic [2:0] STATE;

    int checks = 0;
    int failures = 0;
    int ce_count = 0;
    int ce_base;

    countdown_ctrl #(.ALARM_SEC(8'd3)) dut (
        .CP(CP), .CR(CR), .TICK(TICK), .K_START(K_START), .K_SET(K_SET),
        .K_SEL(K_SEL), .K_INC(K_INC), .TC(TC), .CE(CE), .PE(PE),
        .D_H(D_H), .D_M(D_M), .D_S(D_S), .SEL(SEL), .ALARM(ALARM), .STATE(STATE)
    );

    always #5 CP = ~CP;

    always @(negedge CP) if (CE) ce_count++;

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 = start, 1 = set, 2 = sel, 3 = inc
    task automatic press(input int k);
        K_START = (k == 0);
        K_SET   = (k == 1);
        K_SEL   = (k == 2);
        K_INC   = (k == 3);
        step();
        K_START = 1'b0; K_SET = 1'b0; K_SEL = 1'b0; K_INC = 1'b0;
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) press(3);
    endtask

    initial begin
        // Reset with keys and TC active: reset must win.
        K_SET = 1'b1; K_START = 1'b1; TC = 1'b1; TICK = 1'b1;
        step(); step();
        K_SET = 1'b0; K_START = 1'b0; TC = 1'b0; TICK = 1'b0;
        check("rst_state", STATE, 3'd0);
        check("rst_ce", CE, 1'b0);
        check("rst_pe", PE, 1'b0);
        check("rst_alarm", ALARM, 1'b0);
        check("rst_sel", SEL, 2'd0);
        check("rst_preset", {D_H, D_M, D_S}, 24'h000000);
        CR = 1'b1;
        step();
        check("rst_hold_state", STATE, 3'd0);
        check("rst_hold_preset", {D_H, D_M, D_S}, 24'h000000);

        // Zero preset: K_START ignored.
        press(0);
        check("idle_start_zero", STATE, 3'd0);

        // Basic preset entry.
        press(1);
        check("set_enter", STATE, 3'd1);
        incs(3);
        press(2);
        check("sel_adv", SEL, 2'd1);
        incs(2);
        press(1);
        check("set_exit_state", STATE, 3'd0);
        check("set_exit_pe", PE, 1'b1);
        check("set_exit_ds", D_S, 8'h03);
        check("set_exit_dm", D_M, 8'h02);
        step();
        check("pe_one_cycle", PE, 1'b0);

        // K_SET beats K_START in IDLE; SEL clears on entry (was 1).
        K_SET = 1'b1; K_START = 1'b1;
        step();
        K_SET = 1'b0; K_START = 1'b0;
        check("prio_set_state", STATE, 3'd1);
        check("set_entry_sel0", SEL, 2'd0);
        incs(7);
        check("bcd_carry", D_S, 8'h10);
        incs(49);
        check("ds_59", D_S, 8'h59);
        press(3);
        check("ds_wrap", D_S, 8'h00);
        check("dm_no_carry", D_M, 8'h02);
        press(2); press(2);
        check("sel_2", SEL, 2'd2);
        incs(23);
        check("dh_23", D_H, 8'h23);
        press(3);
        check("dh_wrap", D_H, 8'h00);
        press(2);
        check("sel_wrap", SEL, 2'd0);
        incs(5);
        press(2);
        incs(58);
        check("dm_wrap", D_M, 8'h00);
        press(1);
        check("preset_5s", {D_H, D_M, D_S}, 24'h000005);
        check("set_exit_pe2", PE, 1'b1);

        // RUN / PAUSE with ticks.
        press(0);
        check("run_enter", STATE, 3'd2);
        ce_base = ce_count;
        for (int i = 0; i < 3; i++) begin
            TICK = 1'b1; step(); TICK = 1'b0;
            check("ce_after_tick", CE, 1'b1);
            step();
            check("ce_one_cycle", CE, 1'b0);
        end
        press(0);
        check("pause_enter", STATE, 3'd3);
        for (int i = 0; i < 2; i++) begin
            TICK = 1'b1; step(); TICK = 1'b0;
            check("pause_no_ce", CE, 1'b0);
            step();
        end
        check("ce_pulses", ce_count - ce_base, 3);
        check("pause_state", STATE, 3'd3);
        press(0);
        check("resume", STATE, 3'd2);
        press(1);
        check("run_ignore_set", STATE, 3'd2);

        // TC and K_START together: alarm wins, CE suppressed.
        TC = 1'b1; K_START = 1'b1; TICK = 1'b1;
        step();
        TC = 1'b0; K_START = 1'b0; TICK = 1'b0;
        check("tc_alarm_state", STATE, 3'd4);
        check("tc_alarm_flag", ALARM, 1'b1);
        check("tc_ce_suppr", CE, 1'b0);
        press(0);
        check("alarm_exit_state", STATE, 3'd0);
        check("alarm_exit_pe", PE, 1'b1);
        check("alarm_exit_flag", ALARM, 1'b0);
        step();
        check("alarm_exit_pe_off", PE, 1'b0);

        // Alarm timeout behaviour.
        press(0);
        TC = 1'b1; step(); TC = 1'b0;
        check("alarm2_state", STATE, 3'd4);
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            TICK = 1'b1; step(); TICK = 1'b0;
            if (i < 2) begin
                check("timeout_hold", ALARM, 1'b1);
                step();
            end
        end
        check("timeout_state", STATE, 3'd0);
        check("timeout_pe", PE, 1'b1);
        step();
        check("timeout_pe_off", PE, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            TICK = 1'b1; step(); TICK = 1'b0;
            step();
        end
        check("no_timeout", ALARM, 1'b1);
        press(1);
        check("alarm_set_exit", STATE, 3'd0);
        check("alarm_set_pe", PE, 1'b1);
`endif

        // PAUSE -> SET clears SEL (SEL was left at 1).
        press(0);
        press(0);
        check("pause2", STATE, 3'd3);
        press(1);
        check("pause_to_set", STATE, 3'd1);
        check("pause_set_sel0", SEL, 2'd0);
        press(1);
        check("pause_set_exit_pe", PE, 1'b1);

        // Reset in mid-RUN coinciding with TICK.
        press(0);
        check("run3", STATE, 3'd2);
        TICK = 1'b1; CR = 1'b0;
        step();
        TICK = 1'b0;
        check("midrun_rst_ce", CE, 1'b0);
        check("midrun_rst_state", STATE, 3'd0);
        check("midrun_rst_preset", {D_H, D_M, D_S}, 24'h000000);
        CR = 1'b1;
        step();
        check("midrun_rst_hold", STATE, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter ALARM_SEC, default 8'd30: number of TICK strobes ALARM stays asserted before auto-clear (used only with the macro in REQ-031).
REQ-002 CP  in  1  clock; all state changes on its rising edge.
REQ-003 CR  in  1  synchronous active-low reset; sampled on the CP rising edge.
REQ-004 TICK  in  1  one-CP-cycle 1 Hz strobe.
REQ-005 K_START  in  1  one-cycle debounced start/pause key pulse.
REQ-006 K_SET  in  1  one-cycle debounced set-mode key pulse.
REQ-007 K_SEL  in  1  one-cycle debounced field-select key pulse.
REQ-008 K_INC  in  1  one-cycle debounced field-increment key pulse.
REQ-009 TC  in  1  time-up flag from the hh:mm:ss down-counter; high while the count is 00:00:00.
REQ-010 CE  out  1  count enable to the down-counter.
REQ-011 PE  out  1  preset load pulse to the down-counter.
REQ-012 D_H, D_M, D_S  out  8 each  two-digit BCD preset values for hours, minutes and seconds.
REQ-013 SEL  out  2  field being edited: 0 = seconds, 1 = minutes, 2 = hours.
REQ-014 ALARM  out  1  high while in the ALARM state.
REQ-015 STATE  out  3  current state encoding, for display and debug.

Function
REQ-016 The FSM SHALL have these states and encodings: IDLE = 0, SET = 1, RUN = 2, PAUSE = 3, ALARM = 4; encodings 5-7 SHALL return to IDLE on the next cycle.
REQ-017 IDLE: K_SET SHALL go to SET; K_START SHALL go to RUN only if the preset is nonzero, otherwise it is ignored.
REQ-018 SET: K_SEL SHALL advance SEL 0->1->2->0; K_INC SHALL increment the selected field; K_SET SHALL go to IDLE and assert PE for exactly one cycle.
REQ-019 Field increment SHALL be BCD: low digit 9 -> 0 with carry to the high digit; D_S and D_M SHALL wrap 59 -> 00 and D_H SHALL wrap 23 -> 00, with no carry between fields.
REQ-020 RUN: CE SHALL be a registered copy of TICK, high for one cycle exactly one cycle after each TICK, and low at all other times and in all other states.
REQ-021 RUN: K_START SHALL go to PAUSE; K_SET SHALL be ignored.
REQ-022 RUN: TC = 1 SHALL go to ALARM on the next edge and suppress CE that cycle; if TC and K_START occur in the same cycle, the ALARM transition wins.
REQ-023 PAUSE: K_START SHALL return to RUN; K_SET SHALL go to SET, abandoning the partial count (PE on SET exit reloads it).
REQ-024 ALARM: K_START or K_SET SHALL go to IDLE and assert PE for one cycle, reloading the stored preset.
REQ-025 If several keys pulse in the same cycle, the priority SHALL be K_SET > K_START > K_SEL > K_INC, except as stated in REQ-022.
REQ-026 PE SHALL be registered and never high in the same cycle as CE.
REQ-027 SEL SHALL be 0 on every entry to SET.

Reset
REQ-028 When CR = 0 at a rising edge, the block SHALL go to IDLE with CE = 0, PE = 0, ALARM = 0, SEL = 0, STATE = 0, D_H = D_M = D_S = 8'h00, and the alarm tick counter cleared.
REQ-029 Reset SHALL override every key and TC in that cycle, including in mid-RUN and mid-ALARM.
REQ-030 Outputs SHALL hold their reset values on the first edge with CR = 1.

Configuration
REQ-031 With COUNTDOWN_ALARM_TIMEOUT_EN defined, ALARM SHALL count TICKs from entry and, on the ALARM_SEC-th TICK, go to IDLE with a one-cycle PE pulse, exactly as a key exit; keys SHALL still exit early.
REQ-032 With COUNTDOWN_ALARM_TIMEOUT_EN undefined, ALARM SHALL persist until K_START or K_SET, and no alarm tick counter SHALL be synthesized.

Verification
REQ-033 Reset, then K_SET, K_INC x3, K_SEL, K_INC x2, K_SET -> D_S = 8'h03, D_M = 8'h02, PE high for exactly 1 cycle, STATE = 0.
REQ-034 In SET with D_S = 8'h59, K_INC -> D_S = 8'h00 and D_M unchanged; with SEL = 2 and D_H = 8'h23, K_INC -> D_H = 8'h00.
REQ-035 Preset 00:00:05, K_START, 3 TICKs, K_START, 2 TICKs -> exactly 3 one-cycle CE pulses, each one cycle after its TICK; STATE = 3.
REQ-036 In RUN, TC and K_START in the same cycle -> STATE = 4, ALARM = 1, CE = 0; then K_START -> STATE = 0, PE pulse, ALARM = 0.
REQ-037 Macro on with ALARM_SEC = 3: ALARM, then 3 TICKs -> IDLE after the third TICK with PE = 1 for one cycle; macro off: ALARM still 1 after 100 TICKs.
REQ-038 CR = 0 in mid-RUN coinciding with TICK -> next cycle CE = 0, STATE = 0, all presets 8'h00.
